// File: rtl/uart_line_responder_if.sv
// rtl/uart_line_responder_if.sv - byte, echo and line-consumer signals of the console responder
interface uart_line_responder_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             line_valid;
  logic [LEN_W-1:0] line_len;
  logic [7:0]       line_sum;
  logic             line_ovf;
  logic [LEN_W-1:0] line_rd_idx;
  logic [7:0]       line_rd_data;
  logic             line_ack;

  modport master (
    output rx_data, rx_valid, tx_ready, line_rd_idx, line_ack,
    input  rx_ready, tx_data, tx_valid, line_valid, line_len, line_sum, line_ovf, line_rd_data
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, line_rd_idx, line_ack,
    output rx_ready, tx_data, tx_valid, line_valid, line_len, line_sum, line_ovf, line_rd_data
  );
endinterface

// File: rtl/uart_line_responder.sv
// rtl/uart_line_responder.sv - prompt, echo and single-line buffer for the uart console
module uart_line_responder #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_line_responder_if.slave bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] BS = 8'h08;

  typedef enum logic [1:0] {PROMPT, WAIT_RX, ECHO, DONE} state_t;

  state_t           state, state_d;
  logic [2:0]       pidx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_m1;
  logic [7:0]       sum;
  logic             ovf;
  logic [7:0]       mem [MAX_LEN];
  logic [7:0]       eq0, eq1, eq2;
  logic [1:0]       ecnt, eidx;
  logic             echo_cr;
  logic             tx_fire, rx_fire, full, store;
  logic [7:0]       prompt_byte, echo_byte, last_byte;

  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign rx_fire   = bus.rx_valid && bus.rx_ready;
  assign full      = (len == LEN_W'(MAX_LEN));
  assign len_m1    = len - LEN_W'(1);
  assign last_byte = mem[len_m1[IDX_W-1:0]];
  assign store     = rx_fire && (bus.rx_data != CR) && (bus.rx_data != BS) && !full;

  always_comb begin
    case (pidx)
      3'd0:    prompt_byte = 8'h31;
      3'd1:    prompt_byte = 8'h35;
      3'd2:    prompt_byte = 8'h31;
      3'd3:    prompt_byte = 8'h3e;
      default: prompt_byte = 8'h20;
    endcase
  end

  always_comb begin
    case (eidx)
      2'd0:    echo_byte = eq0;
      2'd1:    echo_byte = eq1;
      default: echo_byte = eq2;
    endcase
  end

  // tx is driven purely from state so the first prompt byte is visible during reset
  assign bus.tx_valid     = (state == PROMPT) || (state == ECHO);
  assign bus.tx_data      = (state == ECHO) ? echo_byte : prompt_byte;
  assign bus.rx_ready     = (state == WAIT_RX);
  assign bus.line_valid   = (state == DONE);
  assign bus.line_len     = len;
  assign bus.line_sum     = sum;
  assign bus.line_ovf     = ovf;
  assign bus.line_rd_data = (bus.line_rd_idx < len) ? mem[bus.line_rd_idx[IDX_W-1:0]] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PROMPT;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      PROMPT:  if (tx_fire && pidx == 3'd4) state_d = WAIT_RX;
      WAIT_RX: begin
        if (rx_fire) begin
          if (bus.rx_data != BS || len != '0) state_d = ECHO;
        end
      end
      ECHO: begin
        if (tx_fire && eidx == ecnt - 2'd1) state_d = echo_cr ? DONE : WAIT_RX;
      end
      DONE:    if (bus.line_ack) state_d = PROMPT;
      default: state_d = PROMPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pidx    <= '0;
      len     <= '0;
      sum     <= '0;
      ovf     <= 1'b0;
      eq0     <= '0;
      eq1     <= '0;
      eq2     <= '0;
      ecnt    <= '0;
      eidx    <= '0;
      echo_cr <= 1'b0;
    end else begin
      case (state)
        PROMPT: if (tx_fire) pidx <= (pidx == 3'd4) ? 3'd0 : pidx + 3'd1;
        WAIT_RX: begin
          if (rx_fire) begin
            eidx    <= '0;
            echo_cr <= 1'b0;
            if (bus.rx_data == CR) begin
              eq0     <= 8'h0d;
              eq1     <= 8'h0a;
              ecnt    <= 2'd2;
              echo_cr <= 1'b1;
            end else if (bus.rx_data == BS) begin
              if (len != '0) begin
                len  <= len_m1;
                sum  <= sum - last_byte;
                eq0  <= 8'h08;
                eq1  <= 8'h20;
                eq2  <= 8'h08;
                ecnt <= 2'd3;
              end
            end else if (!full) begin
              len  <= len + LEN_W'(1);
              sum  <= sum + bus.rx_data;
              eq0  <= bus.rx_data;
              ecnt <= 2'd1;
            end else begin
              ovf  <= 1'b1;
              eq0  <= 8'h07;
              ecnt <= 2'd1;
            end
          end
        end
        ECHO: if (tx_fire) eidx <= eidx + 2'd1;
        DONE: begin
          if (bus.line_ack) begin
            len <= '0;
            sum <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // buffer contents survive across lines; reads beyond len are masked instead
  always_ff @(posedge clk) begin
    if (state == WAIT_RX && store) mem[len[IDX_W-1:0]] <= bus.rx_data;
  end

endmodule
